branch_resolve_predict: RTL and testbench

// - EX-stage branch resolver with an IF-stage bimodal predictor, for the RV32 pipeline.
// - Evaluates all six RISC-V conditional branches at XLEN width and returns the taken bit to the hazard unit.
// - Looks up a table of 2-bit saturating counters, indexed by PCF, so IF can predict.
// - Flags a mispredict in EX, trains the table, and keeps saturating branch/miss statistics.

---
 rtl/branch_resolve_predict_pkg.sv | 30 +++
 rtl/branch_resolve_predict_if.sv | 54 +++++
 rtl/branch_resolve_predict_bht_sat_counter.sv | 25 ++
 rtl/branch_resolve_predict.sv | 100 ++++++++++
 tb/tb_branch_resolve_predict.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_predict_pkg.sv
// Shared types and constants for the EX branch resolver
// and the IF bimodal predictor.
package branch_resolve_predict_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BLTU = 3'd4,
    BR_BGE  = 3'd5,
    BR_BGEU = 3'd6
  } br_type_e;

  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_MAX = 2'b11;
  localparam logic [1:0] CTR_MIN = 2'b00;

  function automatic logic is_cond(
    input logic [2:0] t
  );
    return (t == BR_BEQ)  ||
           (t == BR_BNE)  ||
           (t == BR_BLT)  ||
           (t == BR_BLTU) ||
           (t == BR_BGE)  ||
           (t == BR_BGEU);
  endfunction

endpackage

// File: rtl/branch_resolve_predict_if.sv
// Pipeline-side bundle for the branch resolver:
// IF lookup, EX resolve/train, statistics.
interface branch_resolve_predict_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);

  logic [31:0]      PCF;
  logic             PredTakenF;
  logic [2:0]       BranchTypeE;
  logic [XLEN-1:0]  Operand1;
  logic [XLEN-1:0]  Operand2;
  logic [31:0]      PCE;
  logic             PredTakenE;
  logic             BrValidE;
  logic             StallE;
  logic             BranchE;
  logic             MispredictE;
  logic [CNT_W-1:0] BrCount;
  logic [CNT_W-1:0] MissCount;

  modport master (
    output PCF,
    output BranchTypeE,
    output Operand1,
    output Operand2,
    output PCE,
    output PredTakenE,
    output BrValidE,
    output StallE,
    input  PredTakenF,
    input  BranchE,
    input  MispredictE,
    input  BrCount,
    input  MissCount
  );

  modport slave (
    input  PCF,
    input  BranchTypeE,
    input  Operand1,
    input  Operand2,
    input  PCE,
    input  PredTakenE,
    input  BrValidE,
    input  StallE,
    output PredTakenF,
    output BranchE,
    output MispredictE,
    output BrCount,
    output MissCount
  );

endinterface

// File: rtl/branch_resolve_predict_bht_sat_counter.sv
// One 2-bit saturating branch history counter,
// resets to weakly not-taken.
import branch_resolve_predict_pkg::*;

module bht_sat_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dir,
  output logic [1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= CTR_WNT;
    end else if (en) begin
      if (dir) begin
        if (q != CTR_MAX) q <= q + 2'd1;
      end else begin
        if (q != CTR_MIN) q <= q - 2'd1;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_predict.sv
// EX-stage branch resolver with IF-stage bimodal
// predictor table and saturating statistics.
import branch_resolve_predict_pkg::*;

module branch_resolve_predict #(
  parameter int XLEN      = 32,
  parameter int IDX_BITS  = 6,
  parameter int PRED_MODE = 1,
  parameter int CNT_W     = 32
) (
  input logic CPU_CLK,
  input logic CPU_RST,
  branch_resolve_predict_if.slave bp
);

  localparam int DEPTH = 1 << IDX_BITS;
  localparam bit BIMODAL = (PRED_MODE != 0);

  logic                eq;
  logic                lt;
  logic                ltu;
  logic                taken;
  logic                cond;
  logic                miss;
  logic                upd;
  logic                wen;
  logic [IDX_BITS-1:0] ridx;
  logic [IDX_BITS-1:0] widx;
  logic [1:0]          ctr [DEPTH];
  logic [1:0]          rd;
  logic [CNT_W-1:0]    brc;
  logic [CNT_W-1:0]    msc;

  assign eq  = bp.Operand1 == bp.Operand2;
  assign ltu = bp.Operand1 < bp.Operand2;
  assign lt  = $signed(bp.Operand1)
             < $signed(bp.Operand2);

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      (bp.BranchTypeE == BR_BEQ):  taken = eq;
      (bp.BranchTypeE == BR_BNE):  taken = ~eq;
      (bp.BranchTypeE == BR_BLT):  taken = lt;
      (bp.BranchTypeE == BR_BGE):  taken = ~lt;
      (bp.BranchTypeE == BR_BLTU): taken = ltu;
      (bp.BranchTypeE == BR_BGEU): taken = ~ltu;
      default:                     taken = 1'b0;
    endcase
  end

  assign cond = is_cond(bp.BranchTypeE);
  assign miss = bp.BrValidE & cond
              & (taken != bp.PredTakenE);
  assign upd  = bp.BrValidE & ~bp.StallE & cond;
  assign wen  = upd & BIMODAL;

  assign bp.BranchE     = taken;
  assign bp.MispredictE = miss;

  assign ridx = bp.PCF[IDX_BITS+1:2];
  assign widx = bp.PCE[IDX_BITS+1:2];

  for (genvar i = 0; i < DEPTH; i++) begin : g_bht
    logic en;
    assign en = wen & (widx == IDX_BITS'(i));
    bht_sat_counter u_ctr (
      .clk   (CPU_CLK),
      .rst_n (CPU_RST),
      .en    (en),
      .dir   (taken),
      .q     (ctr[i])
    );
  end

  // Registered table read only; a same-index write shows next cycle
  assign rd = ctr[ridx];
  assign bp.PredTakenF = BIMODAL & rd[1];

  always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
    if (!CPU_RST) begin
      brc <= '0;
      msc <= '0;
    end else if (upd) begin
      if (brc != '1) brc <= brc + 1'b1;
      if (miss && (msc != '1)) msc <= msc + 1'b1;
    end
  end

  assign bp.BrCount   = brc;
  assign bp.MissCount = msc;

  logic unused_bits;
  assign unused_bits = ^{bp.PCF[31:IDX_BITS+2],
                         bp.PCF[1:0],
                         bp.PCE[31:IDX_BITS+2],
                         bp.PCE[1:0],
                         rd[0]};

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Directed bench: default build plus a CNT_W=4,
// PRED_MODE=0 build driven with the same stimulus.
import branch_resolve_predict_pkg::*;

module tb_branch_resolve_predict;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pcf = '0;
  logic [2:0]  bt = BR_NONE;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [31:0] pce = '0;
  logic        ptake = 1'b0;
  logic        bvalid = 1'b0;
  logic        stall = 1'b0;

  int pass_n = 0;
  int total_n = 0;

  logic [31:0] br_m = '0;
  logic [31:0] miss_m = '0;
  logic [3:0]  abr_m = '0;
  logic [3:0]  amiss_m = '0;

  always #5 clk = ~clk;

  branch_resolve_predict_if #(.XLEN(32), .CNT_W(32)) mi ();
  branch_resolve_predict_if #(.XLEN(32), .CNT_W(4))  ai ();

  assign mi.PCF = pcf;
  assign mi.BranchTypeE = bt;
  assign mi.Operand1 = op1;
  assign mi.Operand2 = op2;
  assign mi.PCE = pce;
  assign mi.PredTakenE = ptake;
  assign mi.BrValidE = bvalid;
  assign mi.StallE = stall;

  assign ai.PCF = pcf;
  assign ai.BranchTypeE = bt;
  assign ai.Operand1 = op1;
  assign ai.Operand2 = op2;
  assign ai.PCE = pce;
  assign ai.PredTakenE = ptake;
  assign ai.BrValidE = bvalid;
  assign ai.StallE = stall;

  branch_resolve_predict #(
    .XLEN(32), .IDX_BITS(6), .PRED_MODE(1), .CNT_W(32)
  ) u_main (
    .CPU_CLK (clk),
    .CPU_RST (rst),
    .bp      (mi.slave)
  );

  branch_resolve_predict #(
    .XLEN(32), .IDX_BITS(6), .PRED_MODE(0), .CNT_W(4)
  ) u_alt (
    .CPU_CLK (clk),
    .CPU_RST (rst),
    .bp      (ai.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total_n++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else
      pass_n++;
  endtask

  task automatic mdl(input logic tk, input logic pt);
    if (br_m != '1) br_m++;
    if (abr_m != '1) abr_m++;
    if (tk != pt) begin
      if (miss_m != '1) miss_m++;
      if (amiss_m != '1) amiss_m++;
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_brc"}, mi.BrCount, br_m);
    chk({tag, "_msc"}, mi.MissCount, miss_m);
    chk({tag, "_abrc"}, {28'd0, ai.BrCount}, {28'd0, abr_m});
    chk({tag, "_amsc"}, {28'd0, ai.MissCount}, {28'd0, amiss_m});
  endtask

  task automatic br(input string tag,
                    input logic [2:0] t,
                    input logic [31:0] a, b, pc,
                    input logic pt, tk);
    bt = t; op1 = a; op2 = b; pce = pc;
    ptake = pt; bvalid = 1'b1; stall = 1'b0;
    #1;
    chk({tag, "_brE"}, {31'd0, mi.BranchE}, {31'd0, tk});
    chk({tag, "_misE"}, {31'd0, mi.MispredictE},
        {31'd0, tk != pt});
    @(posedge clk); #1;
    bvalid = 1'b0;
    mdl(tk, pt);
    chk_cnt(tag);
  endtask

  task automatic comb(input string tag,
                      input logic [2:0] t,
                      input logic [31:0] a, b,
                      input logic tk);
    bt = t; op1 = a; op2 = b; #1;
    chk(tag, {31'd0, mi.BranchE}, {31'd0, tk});
  endtask

  initial begin
    #2;
    chk("rst_brc", mi.BrCount, 32'd0);
    chk("rst_msc", mi.MissCount, 32'd0);
    chk("rst_pred", {31'd0, mi.PredTakenF}, 32'd0);
    comb("rst_comb", BR_BEQ, 32'd5, 32'd5, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    comb("bge_eq", BR_BGE, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b1);
    comb("bgeu", BR_BGEU, 32'd1, 32'hFFFF_FFFF, 1'b0);
    comb("blt", BR_BLT, 32'h8000_0000, 32'd0, 1'b1);
    comb("bltu", BR_BLTU, 32'h8000_0000, 32'd0, 1'b0);
    comb("bne", BR_BNE, 32'd7, 32'd7, 1'b0);
    comb("undef", 3'd7, 32'd7, 32'd7, 1'b0);
    bt = BR_NONE; ptake = 1'b1; bvalid = 1'b1; #1;
    chk("none_mis", {31'd0, mi.MispredictE}, 32'd0);
    @(posedge clk); #1;
    bvalid = 1'b0; ptake = 1'b0;
    chk_cnt("none");

    pcf = 32'h40;
    br("t2a", BR_BEQ, 32'd1, 32'd1, 32'h40, 1'b0, 1'b1);
    chk("t2a_pred", {31'd0, mi.PredTakenF}, 32'd1);
    br("t2b", BR_BEQ, 32'd1, 32'd1, 32'h40, 1'b1, 1'b1);
    br("t2c", BR_BEQ, 32'd1, 32'd1, 32'h40, 1'b1, 1'b1);
    chk("t2_pred", {31'd0, mi.PredTakenF}, 32'd1);
    chk("t2_apred", {31'd0, ai.PredTakenF}, 32'd0);

    br("t3a", BR_BEQ, 32'd1, 32'd2, 32'h40, 1'b1, 1'b0);
    chk("t3a_pred", {31'd0, mi.PredTakenF}, 32'd1);
    br("t3b", BR_BLTU, 32'd5, 32'd3, 32'h40, 1'b1, 1'b0);
    chk("t3b_pred", {31'd0, mi.PredTakenF}, 32'd0);
    br("t3c", BR_BNE, 32'd3, 32'd3, 32'h40, 1'b1, 1'b0);
    chk("t3c_pred", {31'd0, mi.PredTakenF}, 32'd0);

    pcf = 32'h44;
    bt = BR_BGEU; op1 = 32'd5; op2 = 32'd5;
    pce = 32'h44; ptake = 1'b0;
    bvalid = 1'b1; stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("stl_brc", mi.BrCount, br_m);
      chk("stl_pred", {31'd0, mi.PredTakenF}, 32'd0);
    end
    stall = 1'b0; #1;
    chk("stl_misE", {31'd0, mi.MispredictE}, 32'd1);
    @(posedge clk); #1;
    bvalid = 1'b0;
    mdl(1'b1, 1'b0);
    chk_cnt("stl");
    chk("stl_pred1", {31'd0, mi.PredTakenF}, 32'd1);
    br("stl_nt", BR_BEQ, 32'd1, 32'd2, 32'h44, 1'b1, 1'b0);
    chk("stl_once", {31'd0, mi.PredTakenF}, 32'd0);

    pcf = 32'h80;
    bt = BR_BEQ; op1 = 32'd7; op2 = 32'd7;
    pce = 32'h80; ptake = 1'b0; bvalid = 1'b1; #1;
    chk("byp_old", {31'd0, mi.PredTakenF}, 32'd0);
    @(posedge clk); #1;
    bvalid = 1'b0;
    mdl(1'b1, 1'b0);
    chk("byp_new", {31'd0, mi.PredTakenF}, 32'd1);

    pcf = 32'hC0;
    for (int i = 0; i < 20; i++) begin
      if (abr_m == 4'hE) break;
      br("fill", BR_BEQ, 32'd0, 32'd0, 32'hC0, 1'b0, 1'b1);
    end
    chk("sat_pre", {28'd0, ai.BrCount}, 32'hE);
    for (int i = 0; i < 3; i++) begin
      br("sat", BR_BEQ, 32'd0, 32'd0, 32'hC0, 1'b0, 1'b1);
      chk("sat_hold", {28'd0, ai.BrCount}, 32'hF);
    end
    chk("sat_miss", {28'd0, ai.MissCount}, 32'hF);
    chk("c0_pred", {31'd0, mi.PredTakenF}, 32'd1);

    bt = BR_BEQ; op1 = '0; op2 = '0; pce = 32'hC0;
    bvalid = 1'b1; stall = 1'b1;
    @(posedge clk); #3;
    rst = 1'b0; #1;
    br_m = '0; miss_m = '0; abr_m = '0; amiss_m = '0;
    chk_cnt("arst");
    chk("arst_pc0", {31'd0, mi.PredTakenF}, 32'd0);
    pcf = 32'h80; #1;
    chk("arst_p80", {31'd0, mi.PredTakenF}, 32'd0);
    chk("arst_comb", {31'd0, mi.BranchE}, 32'd1);
    @(negedge clk);
    rst = 1'b1; bvalid = 1'b0; stall = 1'b0;
    br("post", BR_BLT, 32'hFFFF_FFFF, 32'd1, 32'h80, 1'b0, 1'b1);
    chk("post_pred", {31'd0, mi.PredTakenF}, 32'd1);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
